fft_stage_sequencer: RTL and testbench

Control block for the radix-2 FFT datapath: ping-pong BRAM pair, butterfly, twiddle ROM. After a frame is loaded it issues every stage's butterfly read addresses, twiddle address, bank select and delayed write addresses/enables. It replaces ad-hoc address control inside the FFT top level. The butterfly and both RAMs stay outside this block.

---
 rtl/fft_stage_sequencer.sv | 235 +++++++++++++++++++++++
 tb/tb_fft_stage_sequencer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_stage_sequencer.sv
// Address/strobe sequencer for a radix-2 ping-pong FFT datapath.
// Walks every stage's butterflies, then drains the datapath before swapping banks.
module fft_stage_sequencer #(
    parameter int unsigned N           = 64,
    parameter int unsigned ADDR_WIDTH  = $clog2(N),
    parameter int unsigned STAGE_WIDTH = (ADDR_WIDTH > 1) ? $clog2(ADDR_WIDTH) : 1,
    parameter int unsigned RAM_LATENCY = 1,
    parameter int unsigned BF_LATENCY  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    output logic                    busy,
    output logic                    done,
    output logic                    result_bank,
    output logic [STAGE_WIDTH-1:0]  stage,
    output logic                    rd_en,
    output logic                    rd_bank,
    output logic [ADDR_WIDTH-1:0]   rd_addr_a,
    output logic [ADDR_WIDTH-1:0]   rd_addr_b,
    output logic [ADDR_WIDTH-2:0]   tf_addr,
    output logic                    wr_en,
    output logic                    wr_bank,
    output logic [ADDR_WIDTH-1:0]   wr_addr_a,
    output logic [ADDR_WIDTH-1:0]   wr_addr_b
);

    localparam int unsigned D    = RAM_LATENCY + BF_LATENCY;
    localparam int unsigned HALF = N / 2;
    localparam int unsigned HW   = ADDR_WIDTH - 1;
    localparam int unsigned CW   = (D > 1) ? $clog2(D) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [HW-1:0]          j_q, j_d;
    logic [HW-1:0]          mask_q, mask_d;
    logic [ADDR_WIDTH-1:0]  span_q, span_d;
    logic [STAGE_WIDTH-1:0] stage_q, stage_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   flush;

    logic                   rd_en_d;
    logic                   busy_d;
    logic                   done_d;
    logic                   result_bank_d;
    logic                   rd_bank_d;
    logic [ADDR_WIDTH-1:0]  j_ext;
    logic [ADDR_WIDTH-1:0]  m_ext;
    logic [ADDR_WIDTH-1:0]  addr_a_raw;
    logic [ADDR_WIDTH-1:0]  rd_addr_a_d;
    logic [ADDR_WIDTH-1:0]  rd_addr_b_d;
    logic [HW-1:0]          tf_addr_d;

    // Write-side delay line: strobe, bank and addresses travel D cycles behind the read
    logic                   dl_en   [D];
    logic                   dl_bank [D];
    logic [ADDR_WIDTH-1:0]  dl_a    [D];
    logic [ADDR_WIDTH-1:0]  dl_b    [D];

    // State and counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            j_q     <= '0;
            mask_q  <= '0;
            span_q  <= '0;
            stage_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            j_q     <= j_d;
            mask_q  <= mask_d;
            span_q  <= span_d;
            stage_q <= stage_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, counters and next output values
    always_comb begin
        state_d       = state_q;
        j_d           = j_q;
        mask_d        = mask_q;
        span_d        = span_q;
        stage_d       = stage_q;
        cnt_d         = cnt_q;
        flush         = 1'b0;
        rd_en_d       = 1'b0;
        busy_d        = 1'b0;
        done_d        = 1'b0;
        result_bank_d = 1'b0;
        rd_bank_d     = 1'b0;
        j_ext         = '0;
        m_ext         = '0;
        addr_a_raw    = '0;
        rd_addr_a_d   = '0;
        rd_addr_b_d   = '0;
        tf_addr_d     = '0;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                    flush   = 1'b1;
                end else if (j_q == HW'(HALF - 1)) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else begin
                    j_d = j_q + HW'(1);
                end
            end
            DRAIN: begin
                if (abort) begin
                    state_d = IDLE;
                    flush   = 1'b1;
                end else if (cnt_q == CW'(D - 1)) begin
                    if (stage_q == STAGE_WIDTH'(ADDR_WIDTH - 1)) begin
                        state_d = FIN;
                    end else begin
                        state_d = RUN;
                        stage_d = stage_q + STAGE_WIDTH'(1);
                        mask_d  = mask_q >> 1;
                        span_d  = span_q >> 1;
                        j_d     = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Entering or sitting in IDLE (or a fresh start) reloads the stage-0 geometry
        if (state_d == IDLE || state_q == IDLE) begin
            j_d     = '0;
            stage_d = '0;
            cnt_d   = '0;
            mask_d  = HW'(HALF - 1);
            span_d  = ADDR_WIDTH'(HALF);
        end

        rd_en_d       = (state_d == RUN);
        busy_d        = (state_d == RUN) || (state_d == DRAIN);
        done_d        = (state_d == FIN);
        result_bank_d = (state_d == FIN) && !stage_d[0];
        rd_bank_d     = stage_d[0];

        // Insert a zero at the mask boundary: low bits stay, high bits shift up one
        j_ext      = ADDR_WIDTH'(j_d);
        m_ext      = ADDR_WIDTH'(mask_d);
        addr_a_raw = (j_ext & m_ext) | ((j_ext & ~m_ext) << 1);
        if (rd_en_d) begin
            rd_addr_a_d = addr_a_raw;
            rd_addr_b_d = addr_a_raw + span_d;
            tf_addr_d   = j_d & ~mask_d;
        end
    end

    // Registered read-side outputs and status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_en       <= 1'b0;
            rd_bank     <= 1'b0;
            rd_addr_a   <= '0;
            rd_addr_b   <= '0;
            tf_addr     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            result_bank <= 1'b0;
        end else begin
            rd_en       <= rd_en_d;
            rd_bank     <= rd_bank_d;
            rd_addr_a   <= rd_addr_a_d;
            rd_addr_b   <= rd_addr_b_d;
            tf_addr     <= tf_addr_d;
            busy        <= busy_d;
            done        <= done_d;
            result_bank <= result_bank_d;
        end
    end

    // Delay line fed from the registered read outputs; abort empties it in one edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < D; k++) begin
                dl_en[k]   <= 1'b0;
                dl_bank[k] <= 1'b0;
                dl_a[k]    <= '0;
                dl_b[k]    <= '0;
            end
        end else if (flush) begin
            for (int unsigned k = 0; k < D; k++) begin
                dl_en[k]   <= 1'b0;
                dl_bank[k] <= 1'b0;
                dl_a[k]    <= '0;
                dl_b[k]    <= '0;
            end
        end else begin
            dl_en[0]   <= rd_en;
            dl_bank[0] <= rd_en && !stage_q[0];
            dl_a[0]    <= rd_en ? ADDR_WIDTH'(j_q) : '0;
            dl_b[0]    <= rd_en ? (ADDR_WIDTH'(j_q) + ADDR_WIDTH'(HALF)) : '0;
            for (int unsigned k = 1; k < D; k++) begin
                dl_en[k]   <= dl_en[k-1];
                dl_bank[k] <= dl_bank[k-1];
                dl_a[k]    <= dl_a[k-1];
                dl_b[k]    <= dl_b[k-1];
            end
        end
    end

    assign stage     = stage_q;
    assign wr_en     = dl_en[D-1];
    assign wr_bank   = dl_bank[D-1];
    assign wr_addr_a = dl_a[D-1];
    assign wr_addr_b = dl_b[D-1];

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Scoreboard bench for fft_stage_sequencer: an N=8 and a default N=64 instance side by side.
module tb_fft_stage_sequencer;

    localparam int DLY = 3;

    typedef struct { int cyc; int a; int b; int t; int bank; int stg; } rd_exp_t;
    typedef struct { int cyc; int a; int b; int bank; } wr_exp_t;
    typedef struct { int cyc; int bank; } dn_exp_t;
    typedef struct { int lo; int hi; } win_t;

    logic clk;
    logic rst_n;
    logic start8, abort8, start64, abort64;

    logic       busy8, done8, rbank8, rd_en8, rd_bank8, wr_en8, wr_bank8;
    logic [1:0] stage8;
    logic [2:0] ra8, rb8, wa8, wb8;
    logic [1:0] tf8;

    logic       busy64, done64, rbank64, rd_en64, rd_bank64, wr_en64, wr_bank64;
    logic [2:0] stage64;
    logic [5:0] ra64, rb64, wa64, wb64;
    logic [4:0] tf64;

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;

    rd_exp_t rd_q8[$], rd_q64[$];
    wr_exp_t wr_q8[$], wr_q64[$];
    dn_exp_t dn_q8[$], dn_q64[$];
    win_t    win_q8[$], win_q64[$];

    fft_stage_sequencer #(.N(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .abort(abort8),
        .busy(busy8), .done(done8), .result_bank(rbank8), .stage(stage8),
        .rd_en(rd_en8), .rd_bank(rd_bank8), .rd_addr_a(ra8), .rd_addr_b(rb8),
        .tf_addr(tf8), .wr_en(wr_en8), .wr_bank(wr_bank8),
        .wr_addr_a(wa8), .wr_addr_b(wb8)
    );

    fft_stage_sequencer u_dut64 (
        .clk(clk), .rst_n(rst_n), .start(start64), .abort(abort64),
        .busy(busy64), .done(done64), .result_bank(rbank64), .stage(stage64),
        .rd_en(rd_en64), .rd_bank(rd_bank64), .rd_addr_a(ra64), .rd_addr_b(rb64),
        .tf_addr(tf64), .wr_en(wr_en64), .wr_bank(wr_bank64),
        .wr_addr_a(wa64), .wr_addr_b(wb64)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int pk(input int a, input int b, input int t, input int bk, input int st);
        return (a << 24) | (b << 16) | (t << 8) | (bk << 4) | st;
    endfunction

    function automatic int pending();
        return rd_q8.size() + wr_q8.size() + dn_q8.size()
             + rd_q64.size() + wr_q64.size() + dn_q64.size();
    endfunction

    function automatic int exp_busy(input bit big);
        if (big) begin
            foreach (win_q64[i]) if (win_q64[i].lo <= cyc && cyc <= win_q64[i].hi) return 1;
        end else begin
            foreach (win_q8[i]) if (win_q8[i].lo <= cyc && cyc <= win_q8[i].hi) return 1;
        end
        return 0;
    endfunction

    // Model: stage s has span N>>(s+1); butterflies run group by group, k within group
    task automatic push_frame(input bit big, input int c);
        int n, aw, half, span, base, i;
        rd_exp_t re;
        wr_exp_t we;
        dn_exp_t de;
        win_t    w;
        n    = big ? 64 : 8;
        aw   = big ? 6 : 3;
        half = n / 2;
        for (int s = 0; s < aw; s++) begin
            span = half >> s;
            base = c + 1 + s * (half + DLY);
            i    = 0;
            for (int g = 0; g < half / span; g++) begin
                for (int k = 0; k < span; k++) begin
                    re.cyc = base + i; re.a = g * 2 * span + k; re.b = re.a + span;
                    re.t = g * span; re.bank = s % 2; re.stg = s;
                    we.cyc = base + i + DLY; we.a = i; we.b = i + half; we.bank = 1 - (s % 2);
                    if (big) begin rd_q64.push_back(re); wr_q64.push_back(we); end
                    else begin rd_q8.push_back(re); wr_q8.push_back(we); end
                    i++;
                end
            end
        end
        de.cyc = c + aw * (half + DLY) + 1;
        de.bank = 1 - ((aw - 1) % 2);
        w.lo = c + 1;
        w.hi = c + aw * (half + DLY);
        if (big) begin dn_q64.push_back(de); win_q64.push_back(w); end
        else begin dn_q8.push_back(de); win_q8.push_back(w); end
    endtask

    // Abort sampled at the end of cycle ca: nothing of the N=8 frame may appear afterwards
    task automatic abort_trim(input int ca);
        rd_exp_t rt[$];
        wr_exp_t wt[$];
        dn_exp_t dt[$];
        win_t    vt[$];
        win_t    w;
        foreach (rd_q8[i]) if (rd_q8[i].cyc <= ca) rt.push_back(rd_q8[i]);
        foreach (wr_q8[i]) if (wr_q8[i].cyc <= ca) wt.push_back(wr_q8[i]);
        foreach (dn_q8[i]) if (dn_q8[i].cyc <= ca) dt.push_back(dn_q8[i]);
        foreach (win_q8[i]) begin
            w = win_q8[i];
            if (w.lo <= ca) begin
                if (w.hi > ca) w.hi = ca;
                vt.push_back(w);
            end
        end
        rd_q8 = rt; wr_q8 = wt; dn_q8 = dt; win_q8 = vt;
    endtask

    task automatic sample(input bit big, input int ren, input int rbk, input int stg,
                          input int ra, input int rb, input int tf, input int wen,
                          input int wbk, input int wa, input int wb, input int bsy,
                          input int dn, input int resb);
        string   p;
        int      have;
        rd_exp_t re;
        wr_exp_t we;
        dn_exp_t de;
        p = big ? "d64" : "d8";
        if (ren != 0) begin
            have = big ? rd_q64.size() : rd_q8.size();
            check({p, "_rd_expected"}, int'(have != 0), 1);
            if (have != 0) begin
                if (big) re = rd_q64.pop_front(); else re = rd_q8.pop_front();
                check({p, "_rd_cycle"}, cyc, re.cyc);
                check({p, "_rd_fields"}, pk(ra, rb, tf, rbk, stg), pk(re.a, re.b, re.t, re.bank, re.stg));
            end
        end
        if (wen != 0) begin
            have = big ? wr_q64.size() : wr_q8.size();
            check({p, "_wr_expected"}, int'(have != 0), 1);
            if (have != 0) begin
                if (big) we = wr_q64.pop_front(); else we = wr_q8.pop_front();
                check({p, "_wr_cycle"}, cyc, we.cyc);
                check({p, "_wr_fields"}, pk(wa, wb, 0, wbk, 0), pk(we.a, we.b, 0, we.bank, 0));
            end
        end
        if (dn != 0) begin
            have = big ? dn_q64.size() : dn_q8.size();
            check({p, "_done_expected"}, int'(have != 0), 1);
            if (have != 0) begin
                if (big) de = dn_q64.pop_front(); else de = dn_q8.pop_front();
                check({p, "_done_cycle"}, cyc, de.cyc);
                check({p, "_result_bank"}, resb, de.bank);
            end
        end
        check({p, "_busy"}, bsy, exp_busy(big));
        if (ren != 0 && wen != 0) check({p, "_bank_clash"}, int'(rbk != wbk), 1);
    endtask

    always @(negedge clk) begin
        sample(1'b0, int'(rd_en8), int'(rd_bank8), int'(stage8), int'(ra8), int'(rb8),
               int'(tf8), int'(wr_en8), int'(wr_bank8), int'(wa8), int'(wb8),
               int'(busy8), int'(done8), int'(rbank8));
        sample(1'b1, int'(rd_en64), int'(rd_bank64), int'(stage64), int'(ra64), int'(rb64),
               int'(tf64), int'(wr_en64), int'(wr_bank64), int'(wa64), int'(wb64),
               int'(busy64), int'(done64), int'(rbank64));
    end

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (pending() != 0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        check("wait_done_leftover", pending(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int c;
        rst_n = 1'b0; start8 = 1'b1; start64 = 1'b1; abort8 = 1'b0; abort64 = 1'b0;
        repeat (2) @(negedge clk);
        check("d8_reset_outputs", int'({busy8, done8, rbank8, stage8, rd_en8, rd_bank8, ra8, rb8,
                                        tf8, wr_en8, wr_bank8, wa8, wb8}), 0);
        check("d64_reset_outputs", int'(|{busy64, done64, rbank64, stage64, rd_en64, rd_bank64, ra64,
                                          rb64, tf64, wr_en64, wr_bank64, wa64, wb64}), 0);
        @(posedge clk); #1;
        start8 = 1'b0; start64 = 1'b0; rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // Single frame on both sizes, with a stray start pulse while busy
        c = cyc;
        start8 = 1'b1; start64 = 1'b1;
        push_frame(1'b0, c);
        push_frame(1'b1, c);
        @(posedge clk); #1;
        start8 = 1'b0; start64 = 1'b0;
        while (cyc < c + 5) begin @(posedge clk); #1; end
        start8 = 1'b1; start64 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0; start64 = 1'b0;
        wait_done(400);

        // start held high: one frame per IDLE entry, back to back
        c = cyc;
        start8 = 1'b1;
        push_frame(1'b0, c);
        push_frame(1'b0, c + 23);
        while (cyc < c + 30) begin @(posedge clk); #1; end
        start8 = 1'b0;
        wait_done(200);

        // Abort in stage 1 mid-RUN
        c = cyc;
        start8 = 1'b1;
        push_frame(1'b0, c);
        @(posedge clk); #1;
        start8 = 1'b0;
        while (cyc < c + 10) begin @(posedge clk); #1; end
        abort8 = 1'b1;
        abort_trim(cyc);
        @(posedge clk); #1;
        abort8 = 1'b0;
        @(negedge clk);
        check("abort_rd_en", int'(rd_en8), 0);
        check("abort_wr_en", int'(wr_en8), 0);
        check("abort_busy", int'(busy8), 0);
        repeat (3) @(posedge clk);
        #1;

        // abort and start together in IDLE: abort wins
        abort8 = 1'b1; start8 = 1'b1;
        @(posedge clk); #1;
        abort8 = 1'b0; start8 = 1'b0;
        @(negedge clk);
        check("abort_start_idle_busy", int'(busy8), 0);
        repeat (4) @(posedge clk);
        #1;

        // Full normal sequence after the abort
        c = cyc;
        start8 = 1'b1;
        push_frame(1'b0, c);
        @(posedge clk); #1;
        start8 = 1'b0;
        wait_done(100);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
